// File: rtl/gol_generation_controller.sv
// ============================================================================
// gol_generation_controller: sequences load/step/free-run of a 16x16 Life board
// Revision: 1.0
// ============================================================================
`default_nettype none

module gol_generation_controller #(
  parameter int TIMEOUT = 1024
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cmd_load,
  input  logic [255:0] seed_board,
  input  logic         cmd_run,
  input  logic         cmd_pause,
  input  logic         cmd_step,
  input  logic [23:0]  period,
  output logic         eng_start,
  output logic [255:0] eng_board,
  input  logic [255:0] eng_result,
  input  logic         eng_done,
  output logic [255:0] cur_board,
  output logic [31:0]  generation,
  output logic         busy,
  output logic         halted_stable,
  output logic         halted_empty,
  output logic         err_timeout,
  output logic [2:0]   state
);

  localparam logic [2:0]  ST_IDLE     = 3'd0;
  localparam logic [2:0]  ST_RUN_WAIT = 3'd1;
  localparam logic [2:0]  ST_ISSUE    = 3'd2;
  localparam logic [2:0]  ST_BUSY     = 3'd3;
  localparam logic [2:0]  ST_HALTED   = 3'd4;
  localparam logic [31:0] TO_LAST     = 32'(TIMEOUT - 1);

  logic        running;
  logic [23:0] tick_cnt;
  logic [31:0] to_cnt;
  logic        do_load;
  logic        do_pause;
  logic        do_step;
  logic        do_run;
  logic        res_stable;
  logic        res_empty;

  // Only the highest-priority command of a cycle survives, even if it is then ignored.
  assign do_load  = cmd_load;
  assign do_pause = cmd_pause & ~cmd_load;
  assign do_step  = cmd_step & ~cmd_load & ~cmd_pause;
  assign do_run   = cmd_run & ~cmd_load & ~cmd_pause & ~cmd_step;

  assign res_stable = (eng_result == cur_board);
  assign res_empty  = (eng_result == '0);

  assign eng_start = (state == ST_ISSUE);
  assign busy      = (state == ST_ISSUE) || (state == ST_BUSY);
  assign eng_board = cur_board;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      cur_board     <= '0;
      generation    <= '0;
      halted_stable <= 1'b0;
      halted_empty  <= 1'b0;
      err_timeout   <= 1'b0;
      running       <= 1'b0;
      tick_cnt      <= '0;
      to_cnt        <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_HALTED: begin
          if (do_load) begin
            cur_board     <= seed_board;
            generation    <= '0;
            halted_stable <= 1'b0;
            halted_empty  <= 1'b0;
            err_timeout   <= 1'b0;
            running       <= 1'b0;
            state         <= ST_IDLE;
          end else if (state == ST_IDLE && do_step) begin
            running <= 1'b0;
            state   <= ST_ISSUE;
          end else if (state == ST_IDLE && do_run) begin
            running  <= 1'b1;
            tick_cnt <= '0;
            state    <= ST_RUN_WAIT;
          end
        end
        ST_RUN_WAIT: begin
          if (do_pause) begin
            running <= 1'b0;
            state   <= ST_IDLE;
          end else begin
            tick_cnt <= tick_cnt + 24'd1;
            if (tick_cnt >= period) state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (do_pause) running <= 1'b0;
          to_cnt <= '0;
          state  <= ST_BUSY;
        end
        ST_BUSY: begin
          if (eng_done) begin
            cur_board     <= eng_result;
            halted_stable <= res_stable;
            halted_empty  <= res_empty;
            if (generation != 32'hFFFF_FFFF) generation <= generation + 32'd1;
            if (res_stable || res_empty) begin
              running <= 1'b0;
              state   <= ST_HALTED;
            end else if (running && !do_pause) begin
              tick_cnt <= '0;
              state    <= ST_RUN_WAIT;
            end else begin
              running <= 1'b0;
              state   <= ST_IDLE;
            end
          end else if (to_cnt == TO_LAST) begin
            err_timeout <= 1'b1;
            running     <= 1'b0;
            state       <= ST_HALTED;
          end else begin
            if (do_pause) running <= 1'b0;
            to_cnt <= to_cnt + 32'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_gol_generation_controller.sv
// ============================================================================
// tb_gol_generation_controller: directed self-checking bench for the controller
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_gol_generation_controller;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         cmd_load = 1'b0;
  logic [255:0] seed_board = '0;
  logic         cmd_run = 1'b0;
  logic         cmd_pause = 1'b0;
  logic         cmd_step = 1'b0;
  logic [23:0]  period = '0;
  logic         eng_start;
  logic [255:0] eng_board;
  logic [255:0] eng_result = '0;
  logic         eng_done = 1'b0;
  logic [255:0] cur_board;
  logic [31:0]  generation;
  logic         busy;
  logic         halted_stable;
  logic         halted_empty;
  logic         err_timeout;
  logic [2:0]   state;

  int n_cmp = 0;
  int n_err = 0;

  logic [255:0] horiz, vert, blockp, single, held;
  int n, starts, last, spacing_bad, cnt, pause_sent;

  gol_generation_controller #(.TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .cmd_load(cmd_load), .seed_board(seed_board),
    .cmd_run(cmd_run), .cmd_pause(cmd_pause), .cmd_step(cmd_step), .period(period),
    .eng_start(eng_start), .eng_board(eng_board), .eng_result(eng_result),
    .eng_done(eng_done), .cur_board(cur_board), .generation(generation),
    .busy(busy), .halted_stable(halted_stable), .halted_empty(halted_empty),
    .err_timeout(err_timeout), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [255:0] b);
    seed_board = b;
    cmd_load   = 1'b1;
    cyc();
    cmd_load   = 1'b0;
  endtask

  initial begin
    horiz  = '0; horiz[17] = 1'b1; horiz[18] = 1'b1; horiz[19] = 1'b1;
    vert   = '0; vert[2] = 1'b1; vert[18] = 1'b1; vert[34] = 1'b1;
    blockp = '0; blockp[0] = 1'b1; blockp[1] = 1'b1; blockp[16] = 1'b1; blockp[17] = 1'b1;
    single = '0; single[0] = 1'b1;

    // reset state
    cyc(); cyc();
    reset = 1'b0;
    cyc();
    check("rst_state", 256'(state), 256'(0));
    check("rst_board", cur_board, '0);
    check("rst_gen", 256'(generation), 256'(0));
    check("rst_busy_start", 256'({busy, eng_start}), 256'(0));
    check("rst_flags", 256'({halted_stable, halted_empty, err_timeout}), 256'(0));

    // blinker single step
    load(horiz);
    check("blk_loaded", cur_board, horiz);
    cmd_step = 1'b1;
    cyc();
    cmd_step = 1'b0;
    check("step_issue", 256'({state, eng_start, busy}), 256'({3'd2, 1'b1, 1'b1}));
    check("step_board", eng_board, horiz);
    cyc();
    check("step_busy", 256'({state, eng_start}), 256'({3'd3, 1'b0}));
    cyc(); cyc();
    check("busy_board_hold", eng_board, horiz);
    eng_result = vert; eng_done = 1'b1;
    cyc();
    eng_done = 1'b0;
    check("blk_commit_board", cur_board, vert);
    check("blk_commit_gen", 256'(generation), 256'(1));
    check("blk_commit_state", 256'(state), 256'(0));
    check("blk_flags", 256'({halted_stable, halted_empty, err_timeout}), 256'(0));

    // block still life, free-run with period 3
    load(blockp);
    check("blkp_gen0", 256'(generation), 256'(0));
    period = 24'd3; cmd_run = 1'b1;
    cyc();
    cmd_run = 1'b0;
    check("run_wait", 256'(state), 256'(1));
    n = 0;
    while (state != 3'd2 && n < 20) begin cyc(); n++; end
    check("run_wait_len", 256'(n), 256'(4));
    cyc();
    eng_result = blockp; eng_done = 1'b1;
    cyc();
    eng_done = 1'b0;
    check("still_halt", 256'({state, halted_stable, halted_empty}), 256'({3'd4, 1'b1, 1'b0}));
    check("still_gen", 256'(generation), 256'(1));
    cmd_run = 1'b1;
    cyc();
    cmd_run = 1'b0; cmd_step = 1'b1;
    cyc();
    cmd_step = 1'b0;
    check("halted_ignores", 256'({state, eng_start}), 256'({3'd4, 1'b0}));

    // single cell dies out
    load(single);
    check("reload_flags", 256'({state, halted_stable, halted_empty, generation}), 256'({3'd0, 2'b00, 32'd0}));
    cmd_step = 1'b1; cyc(); cmd_step = 1'b0;
    cyc();
    eng_result = '0; eng_done = 1'b1;
    cyc();
    eng_done = 1'b0;
    check("empty_halt", 256'({state, halted_stable, halted_empty}), 256'({3'd4, 1'b0, 1'b1}));
    check("empty_board", cur_board, '0);
    load(horiz);
    check("empty_reload", 256'({state, halted_empty, generation}), 256'({3'd0, 1'b0, 32'd0}));

    // engine timeout
    cmd_step = 1'b1; cyc(); cmd_step = 1'b0;
    cyc();
    check("to_enter_busy", 256'(state), 256'(3));
    n = 0;
    while (state == 3'd3 && n < 40) begin cyc(); n++; end
    check("to_cycles", 256'(n), 256'(16));
    check("to_halt", 256'({state, err_timeout}), 256'({3'd4, 1'b1}));
    check("to_board", cur_board, horiz);
    eng_result = vert; eng_done = 1'b1;
    cyc();
    eng_done = 1'b0;
    check("late_done_ignored", cur_board, horiz);

    // free-run period 0 with pause during the third generation
    load(horiz);
    period = '0; cmd_run = 1'b1;
    cyc();
    cmd_run = 1'b0;
    starts = 0; last = -1; spacing_bad = 0; cnt = 0; pause_sent = 0;
    for (int t = 0; t < 80 && !(state == 3'd0 && pause_sent != 0); t++) begin
      eng_done = 1'b0; cmd_pause = 1'b0;
      if (eng_start) begin
        starts++;
        if (last >= 0 && t - last != 4) spacing_bad++;
        last = t; cnt = 0;
      end
      if (state == 3'd3) begin
        cnt++;
        if (starts == 3 && pause_sent == 0) begin cmd_pause = 1'b1; pause_sent = 1; end
        if (cnt == 2) begin
          eng_done   = 1'b1;
          eng_result = (eng_board == horiz) ? vert : horiz;
        end
      end
      cyc();
    end
    eng_done = 1'b0; cmd_pause = 1'b0;
    check("run_starts", 256'(starts), 256'(3));
    check("run_spacing", 256'(spacing_bad), 256'(0));
    check("pause_idle", 256'({state, generation}), 256'({3'd0, 32'd3}));
    check("pause_board", cur_board, vert);
    n = 0;
    for (int t = 0; t < 10; t++) begin
      if (eng_start) n++;
      cyc();
    end
    check("pause_no_start", 256'(n), 256'(0));

    // load and step together in IDLE
    seed_board = horiz; cmd_load = 1'b1; cmd_step = 1'b1;
    cyc();
    cmd_load = 1'b0; cmd_step = 1'b0;
    check("load_step", 256'({state, eng_start, generation}), 256'({3'd0, 1'b0, 32'd0}));
    cyc();
    check("load_step_no_issue", 256'({state, eng_start}), 256'({3'd0, 1'b0}));
    check("load_step_board", cur_board, horiz);

    // reset during BUSY, then a late eng_done
    cmd_step = 1'b1; cyc(); cmd_step = 1'b0;
    cyc();
    check("pre_rst_busy", 256'(state), 256'(3));
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    eng_result = vert; eng_done = 1'b1;
    cyc();
    eng_done = 1'b0;
    held = cur_board;
    check("rst_busy_board", held, '0);
    check("rst_busy_outs", 256'({state, eng_start, busy, generation}), 256'({3'd0, 1'b0, 1'b0, 32'd0}));
    check("rst_busy_flags", 256'({halted_stable, halted_empty, err_timeout}), 256'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/gol_generation_controller.md
GOL_GENERATION_CONTROLLER -- requirements
Module: gol_generation_controller

Interface
REQ-001 Parameter TIMEOUT, default 1024: max cycles in BUSY awaiting eng_done.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 cmd_load  in  1  pulse: load seed_board as generation 0.
REQ-005 seed_board  in  256  seed pattern; bit i = cell (row i/16, col i%16).
REQ-006 cmd_run  in  1  pulse: free-run generations.
REQ-007 cmd_pause  in  1  pulse: stop free-run.
REQ-008 cmd_step  in  1  pulse: compute exactly one generation.
REQ-009 period  in  24  idle cycles between generations in free-run.
REQ-010 eng_start  out  1  one-cycle pulse to the next-state engine.
REQ-011 eng_board  out  256  board presented to the engine; equals cur_board.
REQ-012 eng_result  in  256  engine next-state board, valid when eng_done=1.
REQ-013 eng_done  in  1  engine completion pulse.
REQ-014 cur_board  out  256  current committed generation.
REQ-015 generation  out  32  committed generation count.
REQ-016 busy  out  1  high in ISSUE or BUSY.
REQ-017 halted_stable / halted_empty / err_timeout  out  1 each  sticky halt causes.
REQ-018 state  out  3  IDLE=0, RUN_WAIT=1, ISSUE=2, BUSY=3, HALTED=4.

Function
REQ-019 Command priority on the same cycle: load > pause > step > run; lower-priority commands that cycle are dropped.
REQ-020 cmd_load accepted only in IDLE or HALTED: cur_board<=seed_board, generation<=0, halt/error flags<=0, running<=0, state<=IDLE; ignored otherwise.
REQ-021 IDLE + cmd_step: running<=0, state<=ISSUE.
REQ-022 IDLE + cmd_run: running<=1, tick counter<=0, state<=RUN_WAIT.
REQ-023 RUN_WAIT: tick counter increments each cycle; when counter>=period, state<=ISSUE; period=0 gives ISSUE on the next cycle.
REQ-024 RUN_WAIT + cmd_pause: running<=0, state<=IDLE next cycle.
REQ-025 ISSUE/BUSY + cmd_pause: running<=0; the in-flight generation completes and commits, then IDLE.
REQ-026 ISSUE lasts exactly one cycle with eng_start=1, then BUSY; eng_start is 0 in every other state.
REQ-027 eng_board is held stable from ISSUE until BUSY exits.
REQ-028 BUSY + eng_done commit, at the same edge: cur_board<=eng_result; generation<=generation+1, saturating at 0xFFFFFFFF; halted_stable<=(eng_result==cur_board); halted_empty<=(eng_result==0).
REQ-029 Next state after commit: HALTED if either halt flag is set; else RUN_WAIT (tick counter<=0) if running=1; else IDLE.
REQ-030 BUSY timeout: TIMEOUT consecutive cycles without eng_done sets err_timeout, running<=0, state<=HALTED, and leaves cur_board unchanged.
REQ-031 eng_done outside BUSY is ignored and does not change any output.
REQ-032 HALTED exits only via cmd_load; cmd_run, cmd_step and cmd_pause are ignored there.
REQ-033 cmd_step or cmd_run outside IDLE is ignored.
REQ-034 Single-step latency: cmd_step at cycle 0 gives eng_start at cycle 1; eng_done at cycle N gives cur_board/generation updated at cycle N+1.

Reset
REQ-035 On reset: state=IDLE, cur_board=0, generation=0, eng_start=0, busy=0, all flags=0, running=0, tick counter=0, timeout counter=0.
REQ-036 Reset mid-operation aborts immediately; a later eng_done is ignored per REQ-031.
REQ-037 reset overrides every command in the same cycle.

Verification
REQ-038 Blinker seed (bits 17,18,19) + cmd_step, engine model returns the vertical blinker -> cur_board = bits 2,18,34; generation=1; state=IDLE; no halt flags set.
REQ-039 Block still-life seed + cmd_run, period=3 -> first generation commits with halted_stable=1, state=HALTED, generation=1; a later cmd_run is ignored.
REQ-040 Single-cell seed + cmd_step -> halted_empty=1, cur_board=0, state=HALTED; then cmd_load -> flags clear, generation=0.
REQ-041 Engine model never asserts eng_done, TIMEOUT=16 -> err_timeout=1 exactly 16 cycles after entering BUSY; cur_board unchanged.
REQ-042 Blinker seed, cmd_run period=0, cmd_pause during BUSY -> that generation commits, state=IDLE, no further eng_start pulses; eng_start spacing during the run is constant.
REQ-043 cmd_load and cmd_step on the same cycle in IDLE -> load only, state=IDLE, no eng_start; reset asserted during BUSY then late eng_done -> all outputs stay at reset values.
